mbb_seq_ctrl: RTL

- Sequencer that time-multiplexes one 2x2-bit mBB multiplier block to compute a full 2-, 4- or 8-bit operand product.
- Slices operands into 2-bit chunks and drives the chunk pairs to mBB one per cycle, with the correct per-chunk signedness select.
- Sign/zero-extends and shifts each 4-bit partial product and accumulates the 16-bit result.
- Sits in the MFU between the PE operand registers and a single mBB instance; valid/ready on both sides.

---
 rtl/mbb_seq_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mbb_seq_ctrl.sv
// Sequencer that time-multiplexes a single 2x2-bit mBB multiplier to build
// 2-, 4- or 8-bit products, accumulating shifted partial products.
module mbb_seq_ctrl #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [1:0]       prec,
    input  logic             op_signed,
    output logic             mbb_en,
    output logic [1:0]       mbb_a,
    output logic [1:0]       mbb_b,
    output logic [1:0]       mbb_sel,
    input  logic [3:0]       mbb_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_p
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [7:0]       a_q, b_q;
    logic [1:0]       nlog_q;
    logic             sgn_q;
    logic [3:0]       k_q;
    logic [ACC_W-1:0] acc_q;

    logic [3:0]       mask;
    logic [1:0]       cur_i, cur_j;
    logic [3:0]       last_k;
    logic [3:0]       shamt;
    logic [ACC_W-1:0] pp_ext;
    logic [ACC_W-1:0] acc_sum;

    // log2 of the chunk count; prec=11 behaves as 8-bit
    function automatic logic [1:0] nlog_of(input logic [1:0] p);
        return (p == 2'b00) ? 2'd0 : (p == 2'b01) ? 2'd1 : 2'd2;
    endfunction

    // Chunk pair and signedness select for step k: i = k mod N walks A, j = k div N walks B
    function automatic logic [5:0] chunk_of(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] nl, input logic [3:0] k,
                                            input logic sgn);
        logic [3:0] m;
        logic [1:0] i, j, top;
        logic [7:0] as, bs;
        m   = (4'd1 << nl) - 4'd1;
        i   = 2'(k & m);
        j   = 2'(k >> nl);
        top = 2'(m);
        as  = a >> {i, 1'b0};
        bs  = b >> {j, 1'b0};
        return {as[1:0], bs[1:0], sgn & (i == top), sgn & (j == top)};
    endfunction

    // Partial product weight is 4^(i+j); extension follows the select driven this cycle
    always_comb begin
        mask    = (4'd1 << nlog_q) - 4'd1;
        cur_i   = 2'(k_q & mask);
        cur_j   = 2'(k_q >> nlog_q);
        last_k  = (4'd1 << {nlog_q, 1'b0}) - 4'd1;
        shamt   = {3'(cur_i) + 3'(cur_j), 1'b0};
        pp_ext  = (|mbb_sel) ? {{(ACC_W-4){mbb_p[3]}}, mbb_p} : {{(ACC_W-4){1'b0}}, mbb_p};
        acc_sum = acc_q + (pp_ext << shamt);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
            mbb_en    <= 1'b0;
            mbb_a     <= 2'b00;
            mbb_b     <= 2'b00;
            mbb_sel   <= 2'b00;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            nlog_q    <= 2'd0;
            sgn_q     <= 1'b0;
            k_q       <= 4'd0;
            acc_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        nlog_q   <= nlog_of(prec);
                        sgn_q    <= op_signed;
                        k_q      <= 4'd0;
                        acc_q    <= '0;
                        in_ready <= 1'b0;
                        mbb_en   <= 1'b1;
                        {mbb_a, mbb_b, mbb_sel} <= chunk_of(in_a, in_b, nlog_of(prec), 4'd0, op_signed);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_sum;
                    if (k_q == last_k) begin
                        out_p     <= acc_sum;
                        out_valid <= 1'b1;
                        mbb_en    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        k_q <= k_q + 4'd1;
                        {mbb_a, mbb_b, mbb_sel} <= chunk_of(a_q, b_q, nlog_q, k_q + 4'd1, sgn_q);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
